// File: rtl/evm_ballot_unit.sv
// Ballot control stage for the evm vote counter.
// Arms one vote per officer ballot edge, debounces a one-hot candidate press and strobes it out.
module evm_ballot_unit #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int BEEP_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        BALLOT,
    input  logic [3:0]  BTN,
    output logic        VOTE_VALID,
    output logic [1:0]  S,
    output logic        READY,
    output logic        BEEP,
    output logic        ERROR,
    output logic        TIMEOUT,
    output logic [15:0] BALLOTS
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW = $clog2(BEEP_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_DEBOUNCE,
        ST_CAST,
        ST_BEEP,
        ST_RELEASE
    } state_t;

    state_t          state;
    logic            ballot_q;
    logic [3:0]      cap_pat;
    logic [1:0]      cap_idx;
    logic [DW-1:0]   dcnt;
    logic [TW-1:0]   tcnt;
    logic [BW-1:0]   bcnt;

    logic            ballot_edge;
    logic            btn_multi;
    logic            btn_onehot;
    logic [1:0]      btn_idx;
    logic [TW-1:0]   tcnt_next;
    logic [DW-1:0]   dcnt_next;
    logic            t_expire;
    logic            d_done;

    assign ballot_edge = BALLOT & ~ballot_q;
    assign btn_multi   = |(BTN & (BTN - 4'd1));
    assign btn_onehot  = (BTN != 4'd0) && !btn_multi;
    assign tcnt_next   = tcnt + TW'(1);
    assign dcnt_next   = dcnt + DW'(1);
    assign t_expire    = (tcnt_next == TW'(TIMEOUT_CYCLES));
    assign d_done      = (dcnt_next == DW'(DEBOUNCE_CYCLES));

    always_comb begin
        btn_idx = 2'd0;
        case (BTN)
            4'b0010: btn_idx = 2'd1;
            4'b0100: btn_idx = 2'd2;
            4'b1000: btn_idx = 2'd3;
            default: btn_idx = 2'd0;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= ST_IDLE;
            ballot_q   <= 1'b1;
            cap_pat    <= 4'd0;
            cap_idx    <= 2'd0;
            dcnt       <= '0;
            tcnt       <= '0;
            bcnt       <= '0;
            VOTE_VALID <= 1'b0;
            S          <= 2'd0;
            READY      <= 1'b0;
            BEEP       <= 1'b0;
            ERROR      <= 1'b0;
            TIMEOUT    <= 1'b0;
            BALLOTS    <= 16'd0;
        end else begin
            ballot_q   <= BALLOT;
            VOTE_VALID <= 1'b0;
            TIMEOUT    <= 1'b0;
            ERROR      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ballot_edge) begin
                        state <= ST_ARMED;
                        READY <= 1'b1;
                        tcnt  <= '0;
                        dcnt  <= '0;
                        if (BALLOTS != 16'hFFFF) begin
                            BALLOTS <= BALLOTS + 16'd1;
                        end
                    end
                end
                ST_ARMED: begin
                    tcnt  <= tcnt_next;
                    ERROR <= btn_multi;
                    if (t_expire) begin
                        state   <= ST_IDLE;
                        READY   <= 1'b0;
                        TIMEOUT <= 1'b1;
                    end else if (btn_onehot) begin
                        cap_pat <= BTN;
                        cap_idx <= btn_idx;
                        dcnt    <= DW'(1);
                        // A single-sample debounce window casts straight away
                        if (DEBOUNCE_CYCLES == 1) begin
                            state <= ST_CAST;
                            READY <= 1'b0;
                        end else begin
                            state <= ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    tcnt <= tcnt_next;
                    if (t_expire) begin
                        state   <= ST_IDLE;
                        READY   <= 1'b0;
                        TIMEOUT <= 1'b1;
                        dcnt    <= '0;
                    end else if (BTN == cap_pat) begin
                        dcnt <= dcnt_next;
                        if (d_done) begin
                            state <= ST_CAST;
                            READY <= 1'b0;
                        end
                    end else begin
                        dcnt  <= '0;
                        state <= ST_ARMED;
                    end
                end
                ST_CAST: begin
                    VOTE_VALID <= 1'b1;
                    S          <= cap_idx;
                    BEEP       <= 1'b1;
                    bcnt       <= BW'(1);
                    state      <= ST_BEEP;
                end
                ST_BEEP: begin
                    if (bcnt == BW'(BEEP_CYCLES)) begin
                        BEEP  <= 1'b0;
                        state <= ST_RELEASE;
                    end else begin
                        bcnt <= bcnt + BW'(1);
                    end
                end
                ST_RELEASE: begin
                    if (BTN == 4'd0) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    READY <= 1'b0;
                    BEEP  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_evm_ballot_unit.sv
// Directed bench for evm_ballot_unit: a per-cycle vector table plus hand sequences.
module tb_evm_ballot_unit;

    logic        CLK;
    logic        RESET;
    logic        BALLOT;
    logic [3:0]  BTN;
    logic        VOTE_VALID;
    logic [1:0]  S;
    logic        READY;
    logic        BEEP;
    logic        ERROR;
    logic        TIMEOUT;
    logic [15:0] BALLOTS;

    evm_ballot_unit dut (
        .CLK(CLK),
        .RESET(RESET),
        .BALLOT(BALLOT),
        .BTN(BTN),
        .VOTE_VALID(VOTE_VALID),
        .S(S),
        .READY(READY),
        .BEEP(BEEP),
        .ERROR(ERROR),
        .TIMEOUT(TIMEOUT),
        .BALLOTS(BALLOTS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // {VOTE_VALID, S, READY, BEEP, ERROR, TIMEOUT, BALLOTS}
    logic [22:0] outs;
    assign outs = {VOTE_VALID, S, READY, BEEP, ERROR, TIMEOUT, BALLOTS};

    typedef struct {
        logic        ballot;
        logic [3:0]  btn;
        logic [22:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input int n, input logic b, input logic [3:0] bt,
                       input logic vv, input logic [1:0] s, input logic r,
                       input logic bp, input logic e, input logic t,
                       input logic [15:0] bl);
        vec_t v;
        v.ballot = b;
        v.btn    = bt;
        v.exp    = {vv, s, r, bp, e, t, bl};
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    initial begin
        int vv_at;
        int vv_n;
        int to_at;
        int to_n;
        int rdy_n;

        // Scenario 1: vote for candidate 1, button held 10 cycles
        add(1, 1, 4'b0000, 0, 0, 1, 0, 0, 0, 1);
        add(3, 0, 4'b0010, 0, 0, 1, 0, 0, 0, 1);
        add(1, 0, 4'b0010, 0, 0, 0, 0, 0, 0, 1);
        add(1, 0, 4'b0010, 1, 1, 0, 1, 0, 0, 1);
        add(5, 0, 4'b0010, 0, 1, 0, 1, 0, 0, 1);
        add(2, 0, 4'b0000, 0, 1, 0, 1, 0, 0, 1);
        add(2, 0, 4'b0000, 0, 1, 0, 0, 0, 0, 1);
        add(1, 0, 4'b0100, 0, 1, 0, 0, 0, 0, 1);
        // Scenario 2: bounce, then a clean press of candidate 2
        add(1, 1, 4'b0000, 0, 1, 1, 0, 0, 0, 2);
        add(2, 0, 4'b0100, 0, 1, 1, 0, 0, 0, 2);
        add(1, 0, 4'b0000, 0, 1, 1, 0, 0, 0, 2);
        add(3, 0, 4'b0100, 0, 1, 1, 0, 0, 0, 2);
        add(1, 0, 4'b0100, 0, 1, 0, 0, 0, 0, 2);
        add(1, 0, 4'b0000, 1, 2, 0, 1, 0, 0, 2);
        add(7, 0, 4'b0000, 0, 2, 0, 1, 0, 0, 2);
        add(2, 0, 4'b0000, 0, 2, 0, 0, 0, 0, 2);

        RESET  = 1'b1;
        BALLOT = 1'b0;
        BTN    = 4'b0000;
        tick();
        tick();
        chk("reset_state", 32'(outs), 32'd0);
        RESET = 1'b0;
        tick();

        for (int i = 0; i < tbl.size(); i++) begin
            BALLOT = tbl[i].ballot;
            BTN    = tbl[i].btn;
            tick();
            chk($sformatf("vec%0d", i), 32'(outs), 32'(tbl[i].exp));
        end

        // Scenario 3: multi-press rejected, then candidate 3
        BALLOT = 1'b1;
        tick();
        BALLOT = 1'b0;
        chk("s3_ballots", 32'(BALLOTS), 32'd3);
        BTN = 4'b1001;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("s3_error", 32'(ERROR), 32'd1);
            chk("s3_novote", 32'(VOTE_VALID), 32'd0);
        end
        BTN   = 4'b1000;
        vv_at = -1;
        vv_n  = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0) chk("s3_err_clear", 32'(ERROR), 32'd0);
            if (VOTE_VALID) begin
                if (vv_at < 0) vv_at = i;
                vv_n++;
            end
        end
        chk("s3_latency", 32'(vv_at), 32'd4);
        chk("s3_vote_count", 32'(vv_n), 32'd1);
        chk("s3_s", 32'(S), 32'd3);
        BTN = 4'b0000;
        repeat (12) tick();
        chk("s3_idle_ready", 32'(READY), 32'd0);
        chk("s3_idle_beep", 32'(BEEP), 32'd0);

        // Scenario 4: timeout with no press
        BALLOT = 1'b1;
        tick();
        BALLOT = 1'b0;
        chk("s4_ballots", 32'(BALLOTS), 32'd4);
        to_at = -1;
        to_n  = 0;
        vv_n  = 0;
        for (int i = 1; i <= 70; i++) begin
            tick();
            if (i == 63) chk("s4_ready_before", 32'(READY), 32'd1);
            if (TIMEOUT) begin
                if (to_at < 0) to_at = i;
                to_n++;
            end
            if (VOTE_VALID) vv_n++;
        end
        chk("s4_timeout_at", 32'(to_at), 32'd64);
        chk("s4_timeout_pulses", 32'(to_n), 32'd1);
        chk("s4_ready_after", 32'(READY), 32'd0);
        BTN   = 4'b0010;
        rdy_n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (VOTE_VALID) vv_n++;
            if (READY) rdy_n++;
        end
        chk("s4_no_vote", 32'(vv_n), 32'd0);
        chk("s4_no_rearm", 32'(rdy_n), 32'd0);
        BTN = 4'b0000;
        tick();

        // Scenario 5: button held through beep, ballot pressed during beep
        BALLOT = 1'b1;
        tick();
        BALLOT = 1'b0;
        chk("s5_ballots", 32'(BALLOTS), 32'd5);
        BTN  = 4'b0001;
        vv_n = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 6) BALLOT = 1'b1;
            if (i == 8) BALLOT = 1'b0;
            tick();
            if (i == 7) chk("s5_beep_on", 32'(BEEP), 32'd1);
            if (VOTE_VALID) vv_n++;
        end
        chk("s5_vote_count", 32'(vv_n), 32'd1);
        chk("s5_s", 32'(S), 32'd0);
        chk("s5_ballots_kept", 32'(BALLOTS), 32'd5);
        BALLOT = 1'b1;
        tick();
        BALLOT = 1'b0;
        tick();
        chk("s5_release_ready", 32'(READY), 32'd0);
        chk("s5_release_ballots", 32'(BALLOTS), 32'd5);
        BTN = 4'b0000;
        tick();
        tick();
        BALLOT = 1'b1;
        tick();
        chk("s5_rearm_ready", 32'(READY), 32'd1);
        chk("s5_rearm_ballots", 32'(BALLOTS), 32'd6);

        // Scenario 6: async reset during debounce, BALLOT held high
        BTN = 4'b0100;
        tick();
        tick();
        chk("s6_debounce_ready", 32'(READY), 32'd1);
        #2;
        RESET = 1'b1;
        #1;
        chk("s6_async_reset", 32'(outs), 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        rdy_n = 0;
        vv_n  = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (READY) rdy_n++;
            if (VOTE_VALID) vv_n++;
        end
        chk("s6_no_rearm", 32'(rdy_n), 32'd0);
        chk("s6_no_vote", 32'(vv_n), 32'd0);
        BTN    = 4'b0000;
        BALLOT = 1'b0;
        tick();
        BALLOT = 1'b1;
        tick();
        chk("s6_rearm_ready", 32'(READY), 32'd1);
        chk("s6_rearm_ballots", 32'(BALLOTS), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
